// File: rtl/ic_74xxx_pkg.sv
// Shared definitions for the 74xxx logic-family models: per-device width,
// total chain width and the reset levels used by the pin samplers.
package ic_74xxx_pkg;

  localparam int BITS_PER_STAGE = 8;

  // Reset levels: clock pins reset high so a pin already high at reset
  // release is not seen as a rising edge; active-low controls reset inactive.
  localparam logic RST_LVL_CLK   = 1'b1;
  localparam logic RST_LVL_SER   = 1'b0;
  localparam logic RST_LVL_CLR_N = 1'b1;
  localparam logic RST_LVL_OE_N  = 1'b1;

  function automatic int total_width(input int stages);
    return BITS_PER_STAGE * stages;
  endfunction

endpackage

// File: rtl/ic_pin_sampler.sv
// Samples one TTL pin into the clk domain and flags its rising edge.
// Optional IC74595_SYNC_EN: adds a 2-flop synchronizer ahead of the sample
// register (two extra cycles of latency, pulse width rules unchanged).
module ic_pin_sampler #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise
);

  logic w_in;
  logic r_sample;
  logic r_prev;

`ifdef IC74595_SYNC_EN
  logic [1:0] r_sync;

  // Two-stage synchronizer; reset level matches the sample register.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= {2{RST_VAL}};
    else     r_sync <= {r_sync[0], i_pin};
  end

  assign w_in = r_sync[1];
`else
  assign w_in = i_pin;
`endif

  // Sample register plus its delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample <= RST_VAL;
      r_prev   <= RST_VAL;
    end else begin
      r_sample <= w_in;
      r_prev   <= r_sample;
    end
  end

  assign o_level = r_sample;
  assign o_rise  = r_sample & ~r_prev;

endmodule

// File: rtl/ic_74595_chain.sv
// Cascaded 74595 shift/storage register model. Pin clocks are sampled as
// data and edge-detected in clk; they never clock any flop directly.
// Optional IC74595_SYNC_EN (in ic_pin_sampler) synchronizes every pin.
module ic_74595_chain
  import ic_74xxx_pkg::*;
#(
  parameter int   STAGES    = 1,
  parameter logic CLR_VALUE = 1'b0,
  localparam int  W         = total_width(STAGES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ser,
  input  logic         srclk,
  input  logic         rclk,
  input  logic         srclr_n,
  input  logic         oe_n,
  output logic [W-1:0] q,
  output logic [W-1:0] q_oe,
  output logic         qh_ser
);

  logic         w_ser_lvl,   w_ser_rise;
  logic         w_srclk_lvl, w_srclk_rise;
  logic         w_rclk_lvl,  w_rclk_rise;
  logic         w_clr_n_lvl, w_clr_rise;
  logic         w_oe_n_lvl,  w_oe_rise;
  logic         w_unused;
  logic [W-1:0] r_sr;
  logic [W-1:0] r_st;

  ic_pin_sampler #(.RST_VAL(RST_LVL_SER)) u_ser (
    .clk(clk), .rst(rst), .i_pin(ser), .o_level(w_ser_lvl), .o_rise(w_ser_rise)
  );

  ic_pin_sampler #(.RST_VAL(RST_LVL_CLK)) u_srclk (
    .clk(clk), .rst(rst), .i_pin(srclk), .o_level(w_srclk_lvl), .o_rise(w_srclk_rise)
  );

  ic_pin_sampler #(.RST_VAL(RST_LVL_CLK)) u_rclk (
    .clk(clk), .rst(rst), .i_pin(rclk), .o_level(w_rclk_lvl), .o_rise(w_rclk_rise)
  );

  ic_pin_sampler #(.RST_VAL(RST_LVL_CLR_N)) u_srclr_n (
    .clk(clk), .rst(rst), .i_pin(srclr_n), .o_level(w_clr_n_lvl), .o_rise(w_clr_rise)
  );

  ic_pin_sampler #(.RST_VAL(RST_LVL_OE_N)) u_oe_n (
    .clk(clk), .rst(rst), .i_pin(oe_n), .o_level(w_oe_n_lvl), .o_rise(w_oe_rise)
  );

  // Level/edge outputs that this device has no use for.
  assign w_unused = ^{w_srclk_lvl, w_rclk_lvl, w_ser_rise, w_clr_rise, w_oe_rise};

  // Shift and storage registers. Clear wins over shift; the storage latch
  // always captures the shift register as it was before this cycle's update,
  // which makes tied srclk/rclk lag by one shift like the real part.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= '0;
      r_st <= '0;
    end else begin
      if (!w_clr_n_lvl)      r_sr <= {W{CLR_VALUE}};
      else if (w_srclk_rise) r_sr <= {r_sr[W-2:0], w_ser_lvl};
      if (w_rclk_rise)       r_st <= r_sr;
    end
  end

  // Output gating follows the sampled enable without further delay.
  always_comb begin
    q      = w_oe_n_lvl ? '0 : r_st;
    q_oe   = {W{~w_oe_n_lvl}};
    qh_ser = r_sr[W-1];
  end

endmodule

// File: tb/tb_ic_74595_chain.sv
// Bench for ic_74595_chain: one 1-stage and one 2-stage device share the
// same pins; a transaction-level model tracks shift/storage contents.
module tb_ic_74595_chain;

`ifdef IC74595_SYNC_EN
  localparam int XLAT = 2;
`else
  localparam int XLAT = 0;
`endif

  logic clk = 1'b0;
  logic rst, ser, srclk, rclk, srclr_n, oe_n;
  logic [7:0]  q1, q_oe1;
  logic [15:0] q2, q_oe2;
  logic        qh1, qh2;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  logic [7:0]  m_sr1, m_st1;
  logic [15:0] m_sr2, m_st2;
  logic        m_oe_n;

  always #5 clk = ~clk;

  ic_74595_chain #(.STAGES(1), .CLR_VALUE(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .ser(ser), .srclk(srclk), .rclk(rclk),
    .srclr_n(srclr_n), .oe_n(oe_n), .q(q1), .q_oe(q_oe1), .qh_ser(qh1)
  );

  ic_74595_chain #(.STAGES(2), .CLR_VALUE(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .ser(ser), .srclk(srclk), .rclk(rclk),
    .srclr_n(srclr_n), .oe_n(oe_n), .q(q2), .q_oe(q_oe2), .qh_ser(qh2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, " q1"},    {24'd0, q1},    {24'd0, (m_oe_n ? 8'h00 : m_st1)});
    check_val({tag, " q_oe1"}, {24'd0, q_oe1}, {24'd0, {8{~m_oe_n}}});
    check_val({tag, " qh1"},   {31'd0, qh1},   {31'd0, m_sr1[7]});
    check_val({tag, " q2"},    {16'd0, q2},    {16'd0, (m_oe_n ? 16'h0000 : m_st2)});
    check_val({tag, " q_oe2"}, {16'd0, q_oe2}, {16'd0, {16{~m_oe_n}}});
    check_val({tag, " qh2"},   {31'd0, qh2},   {31'd0, m_sr2[15]});
  endtask

  // Clean pulse: high 2 samples, low 2 samples, then settle.
  task automatic pulse(input logic do_sr, input logic do_r, input logic b);
    ser   = b;
    srclk = do_sr;
    rclk  = do_r;
    tick(2);
    srclk = 1'b0;
    rclk  = 1'b0;
    tick(2 + XLAT);
  endtask

  task automatic do_shift(input logic b);
    pulse(1'b1, 1'b0, b);
    if (srclr_n) begin
      m_sr1 = (m_sr1 << 1) | 8'(b);
      m_sr2 = (m_sr2 << 1) | 16'(b);
    end
  endtask

  task automatic do_latch();
    pulse(1'b0, 1'b1, 1'b0);
    m_st1 = m_sr1;
    m_st2 = m_sr2;
  endtask

  task automatic do_tied(input logic b);
    pulse(1'b1, 1'b1, b);
    m_st1 = m_sr1;
    m_st2 = m_sr2;
    m_sr1 = (m_sr1 << 1) | 8'(b);
    m_sr2 = (m_sr2 << 1) | 16'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2 + XLAT);
    check_val("in-reset q1",   {24'd0, q1},    32'd0);
    check_val("in-reset qoe1", {24'd0, q_oe1}, 32'd0);
    check_val("in-reset qh2",  {31'd0, qh2},   32'd0);
    rst = 1'b0;
    m_sr1 = '0; m_st1 = '0; m_sr2 = '0; m_st2 = '0;
    tick(2 + XLAT);
  endtask

  task automatic shift_byte_msb(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) do_shift(v[i]);
  endtask

  initial begin
    logic [15:0] w16;
    logic [7:0]  b8;
    rst = 1'b1; ser = 1'b0; srclk = 1'b0; rclk = 1'b0; srclr_n = 1'b1; oe_n = 1'b0;
    m_oe_n = 1'b0;
    do_reset();

    // Reset then shift 0xA5 MSB-first, latch, with exact rclk latency.
    check_all("post-reset");
    shift_byte_msb(8'hA5);
    check_val("A5 qh after 8 shifts", {31'd0, qh1}, 32'd1);
    check_val("A5 q before latch", {24'd0, q1}, 32'd0);
    rclk = 1'b1;
    tick(1 + XLAT);
    check_val("rclk +1 q unchanged", {24'd0, q1}, 32'd0);
    tick(1);
    check_val("rclk +2 q latched", {24'd0, q1}, 32'hA5);
    rclk = 1'b0;
    tick(2 + XLAT);
    m_st1 = m_sr1; m_st2 = m_sr2;
    check_all("A5 latched");

    // Tied clocks: storage lags shift register by one shift.
    do_reset();
    do_tied(1'b1); do_tied(1'b1); do_tied(1'b0); do_tied(1'b1);
    check_val("tied q[3:0]", {28'd0, q1[3:0]}, 32'h6);
    check_all("tied");

    // Clear priority and latency: shift with ser=1 during clear still clears.
    shift_byte_msb(8'hFF);
    do_latch();
    check_val("pre-clear q", {24'd0, q1}, 32'hFF);
    srclr_n = 1'b0;
    tick(1 + XLAT);
    check_val("clear +1 qh still set", {31'd0, qh1}, 32'd1);
    tick(1);
    check_val("clear +2 qh cleared", {31'd0, qh1}, 32'd0);
    m_sr1 = '0; m_sr2 = '0;
    do_shift(1'b1);
    do_shift(1'b1);
    check_val("clear held q kept", {24'd0, q1}, 32'hFF);
    check_all("clear");
    srclr_n = 1'b1;
    tick(2 + XLAT);
    do_latch();
    check_all("clear latched");

    // Output enable: 1 clk (+sync) from pin to q/q_oe.
    shift_byte_msb(8'h3C);
    do_latch();
    oe_n = 1'b1;
    tick(1 + XLAT);
    check_val("oe off q", {24'd0, q1}, 32'd0);
    check_val("oe off q_oe", {24'd0, q_oe1}, 32'd0);
    oe_n = 1'b0;
    tick(XLAT);
    check_val("oe on before latency", {24'd0, q_oe1}, 32'd0);
    tick(1);
    check_val("oe on q", {24'd0, q1}, 32'h3C);
    check_val("oe on q_oe", {24'd0, q_oe1}, 32'hFF);

    // Cascade: 16 bits into the 2-stage chain, then one more shift out.
    w16 = 16'h1234;
    for (int i = 15; i >= 0; i--) do_shift(w16[i]);
    do_latch();
    check_val("cascade q2", {16'd0, q2}, 32'h1234);
    do_shift(1'b0);
    check_val("cascade qh2 17th", {31'd0, qh2}, 32'd0);
    do_latch();
    check_val("cascade q2 after 17", {16'd0, q2}, 32'h2468);
    check_all("cascade");

    // Reset mid-operation with srclk held high across release.
    do_reset();
    for (int i = 0; i < 5; i++) do_shift(1'b1);
    ser = 1'b1;
    srclk = 1'b1;
    tick(2 + XLAT);
    rst = 1'b1;
    tick(2 + XLAT);
    rst = 1'b0;
    m_sr1 = '0; m_st1 = '0; m_sr2 = '0; m_st2 = '0;
    tick(3 + XLAT);
    srclk = 1'b0;
    tick(2 + XLAT);
    check_all("mid-reset");
    do_latch();
    check_val("no spurious shift q1", {24'd0, q1}, 32'd0);
    check_all("mid-reset latched");

    // Randomized transactions against the model.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0, 1: do_shift(1'($urandom));
        2:    do_latch();
        3:    do_tied(1'($urandom));
        4: begin
          srclr_n = 1'b0;
          tick(2 + XLAT);
          m_sr1 = '0; m_sr2 = '0;
          if ($urandom_range(0, 1) == 1) do_shift(1'($urandom));
          srclr_n = 1'b1;
          tick(2 + XLAT);
        end
        default: begin
          b8 = 8'($urandom);
          oe_n = b8[0];
          m_oe_n = b8[0];
          tick(1 + XLAT);
        end
      endcase
      check_all("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
